// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader: fills matrix A then matrix B from one element
// stream and holds both for the compute stage under a valid/ready frame handshake.
module matrix_operand_loader #(
    parameter int ROW   = 8,
    parameter int COL   = 4,
    parameter int WIDTH = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ROW-1:0][COL-1:0][WIDTH-1:0]     array1,
    output logic [COL-1:0][ROW-1:0][WIDTH-1:0]     array2,
    output logic                                   frame_err
);

    // state  | meaning
    // LOAD_A | filling array1 row-major, j fastest
    // LOAD_B | filling array2, i fastest
    // HOLD   | both matrices complete, waiting for out_ready
    localparam int N    = ROW * COL;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx, idx_nxt;
    logic              err_nxt;
    logic              accept;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD_A;
            idx       <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        case (state)
            LOAD_A: begin
                if (accept) begin
                    // last can only legally arrive on the final B beat
                    if (in_last) begin
                        err_nxt   = 1'b1;
                        state_nxt = LOAD_A;
                        idx_nxt   = '0;
                    end else if (idx == LAST_IDX) begin
                        state_nxt = LOAD_B;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        // a missing last is flagged but the frame is still delivered
                        state_nxt = HOLD;
                        idx_nxt   = '0;
                        err_nxt   = !in_last;
                    end else if (in_last) begin
                        err_nxt   = 1'b1;
                        state_nxt = LOAD_A;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_nxt = LOAD_A;
            end
            default: begin
                state_nxt = LOAD_A;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            array1 <= '0;
            array2 <= '0;
        end else if (accept) begin
            for (int i = 0; i < ROW; i++) begin
                for (int j = 0; j < COL; j++) begin
                    if (state == LOAD_A && idx == IDXW'(i * COL + j))
                        array1[i][j] <= in_data;
                    if (state == LOAD_B && idx == IDXW'(j * ROW + i))
                        array2[j][i] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader with a small reference model of
// the load sequence, framing errors and hold behaviour.
module tb_matrix_operand_loader;

    localparam int ROW   = 8;
    localparam int COL   = 4;
    localparam int WIDTH = 10;
    localparam int N     = ROW * COL;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               in_valid;
    logic                               in_ready;
    logic [WIDTH-1:0]                   in_data;
    logic                               in_last;
    logic                               out_valid;
    logic                               out_ready;
    logic [ROW-1:0][COL-1:0][WIDTH-1:0] array1;
    logic [COL-1:0][ROW-1:0][WIDTH-1:0] array2;
    logic                               frame_err;

    int total = 0;
    int bad   = 0;

    // reference model
    int               m_st;
    int               m_idx;
    logic             m_err;
    logic [WIDTH-1:0] ma [ROW][COL];
    logic [WIDTH-1:0] mb [COL][ROW];

    matrix_operand_loader #(.ROW(ROW), .COL(COL), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .array1(array1), .array2(array2), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_idx = 0; m_err = 1'b0;
        for (int i = 0; i < ROW; i++)
            for (int j = 0; j < COL; j++) begin
                ma[i][j] = '0;
                mb[j][i] = '0;
            end
    endfunction

    function automatic void model_beat(input logic [WIDTH-1:0] d, input logic last);
        m_err = 1'b0;
        if (m_st == 0) begin
            ma[m_idx / COL][m_idx % COL] = d;
            if (last) begin m_err = 1'b1; m_idx = 0; end
            else if (m_idx == N - 1) begin m_st = 1; m_idx = 0; end
            else m_idx++;
        end else if (m_st == 1) begin
            mb[m_idx / ROW][m_idx % ROW] = d;
            if (m_idx == N - 1) begin m_st = 2; m_idx = 0; m_err = !last; end
            else if (last) begin m_err = 1'b1; m_st = 0; m_idx = 0; end
            else m_idx++;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        model_beat(d, last);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_st == 2)});
    endtask

    task automatic chk_arrays(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < ROW; i++)
            for (int j = 0; j < COL; j++) begin
                if (array1[i][j] !== ma[i][j]) errs++;
                if (array2[j][i] !== mb[j][i]) errs++;
            end
        chk(tag, errs, 0);
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_st = 0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic full_frame(input int base, input logic with_last);
        for (int k = 1; k <= 2 * N; k++)
            beat(WIDTH'(base + k), with_last && (k == 2 * N));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk_arrays("rst_arrays");
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: values 1..64 with out_ready held high
        out_ready = 1'b1;
        full_frame(0, 1'b1);
        chk("t1_a00", array1[0][0], 32'd1);
        chk("t1_a73", array1[7][3], 32'd32);
        chk("t1_b00", array2[0][0], 32'd33);
        chk("t1_b37", array2[3][7], 32'd64);
        chk_arrays("t1_arrays");
        idle(1);
        m_st = 0;
        chk("t1_one_cycle", {31'd0, out_valid}, 32'd0);
        chk("t1_back_to_load", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // 2: hold with out_ready low, in_valid pushing
        full_frame(100, 1'b1);
        in_valid = 1'b1; in_data = 10'd999;
        for (int c = 0; c < 10; c++) begin
            idle(1);
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk_arrays("t2_frozen");
        release_frame();

        // 3: early last on beat 20
        for (int k = 1; k <= 20; k++) beat(WIDTH'(200 + k), k == 20);
        idle(1);
        chk("t3_err_pulse_end", {31'd0, frame_err}, 32'd0);
        chk("t3_no_valid", {31'd0, out_valid}, 32'd0);
        full_frame(300, 1'b1);
        chk_arrays("t3_recovery");
        release_frame();

        // 4: missing last still completes
        full_frame(400, 1'b0);
        chk_arrays("t4_arrays");
        idle(1);
        chk("t4_err_pulse_end", {31'd0, frame_err}, 32'd0);
        chk("t4_still_hold", {31'd0, out_valid}, 32'd1);
        release_frame();

        // 6: reset at beat 40
        for (int k = 1; k <= 40; k++) beat(WIDTH'(500 + k), 1'b0);
        rst = 1'b1;
        #3;
        model_reset();
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk_arrays("t6_zero");
        @(posedge clk); #1;
        rst = 1'b0;
        full_frame(600, 1'b1);
        chk_arrays("t6_next_frame");
        release_frame();

        // 5: random gaps and backpressure
        for (int f = 0; f < 100; f++) begin
            for (int k = 1; k <= 2 * N; k++) begin
                while ($urandom_range(1, 0) == 1) idle(1);
                beat(WIDTH'($urandom_range(1023, 0)), k == 2 * N);
            end
            chk_arrays("t5_frame");
            idle($urandom_range(3, 0));
            chk("t5_hold", {31'd0, out_valid}, 32'd1);
            release_frame();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
